// File: rtl/alu16_nibble_seq.sv
// alu16_nibble_seq: streams a 16-bit operation LSB-nibble-first through an external 4-bit ALU slice, chaining carries.
// Define ALU16_ZERO_FLAG_EN to add a registered zero-result output.
module alu16_nibble_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [1:0]  op_ctrl,
  input  logic        cin,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic        alu_c,
  output logic [1:0]  alu_ctrl,
  input  logic [3:0]  alu_d,
  input  logic        alu_e,
  output logic [15:0] result,
  output logic        cout,
  output logic        busy,
`ifdef ALU16_ZERO_FLAG_EN
  output logic        zero,
`endif
  output logic        done
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]  state_q, state_d, cnt_q, cnt_d, ctrl_q, ctrl_d;
  logic [15:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic        cy_q, cy_d, cin_q, cin_d, cout_q, cout_d;
  logic        run, accept, last;
  assign run    = state_q == RUN;
  assign accept = start && !run;
  assign last   = run && cnt_q == 2'd3;
  always_comb begin
    state_d  = accept ? RUN : last ? DONE : run ? RUN : IDLE;
    cnt_d    = accept ? 2'd0 : run ? cnt_q + 2'd1 : cnt_q;
    cy_d     = run ? alu_e : cy_q;
    a_d      = accept ? op_a : a_q;
    b_d      = accept ? op_b : b_q;
    ctrl_d   = accept ? op_ctrl : ctrl_q;
    cin_d    = accept ? cin : cin_q;
    cout_d   = last ? alu_e : cout_q;
    result_d = result_q;
    if (run) result_d[cnt_q*4 +: 4] = alu_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      cy_q     <= 1'b0;
      a_q      <= 16'h0;
      b_q      <= 16'h0;
      ctrl_q   <= 2'd0;
      cin_q    <= 1'b0;
      result_q <= 16'h0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cy_q     <= cy_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
`ifdef ALU16_ZERO_FLAG_EN
  logic zero_q, zero_d;
  assign zero_d = last ? ({alu_d, result_q[11:0]} == 16'h0) : zero_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) zero_q <= 1'b0;
    else zero_q <= zero_d;
  assign zero = zero_q;
`endif
  // Outside RUN the slice sees zeros, but keeps the latched control code.
  assign alu_a    = run ? a_q[cnt_q*4 +: 4] : 4'h0;
  assign alu_b    = run ? b_q[cnt_q*4 +: 4] : 4'h0;
  assign alu_c    = run ? (cnt_q == 2'd0 ? cin_q : cy_q) : 1'b0;
  assign alu_ctrl = ctrl_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign busy     = run;
  assign done     = state_q == DONE;
endmodule

// File: tb/tb_alu16_nibble_seq.sv
// tb_alu16_nibble_seq: directed bench for alu16_nibble_seq with an adder stub standing in for the 4-bit slice.
module tb_alu16_nibble_seq;
  logic        clk, rst, start, cin, alu_c, alu_e, cout, busy, done;
  logic [15:0] op_a, op_b, result;
  logic [1:0]  op_ctrl, alu_ctrl;
  logic [3:0]  alu_a, alu_b, alu_d;
`ifdef ALU16_ZERO_FLAG_EN
  logic zero;
`endif
  int n_cmp = 0, n_err = 0;

  alu16_nibble_seq dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .op_ctrl(op_ctrl), .cin(cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_ctrl(alu_ctrl), .alu_d(alu_d), .alu_e(alu_e),
    .result(result), .cout(cout), .busy(busy),
`ifdef ALU16_ZERO_FLAG_EN
    .zero(zero),
`endif
    .done(done)
  );

  assign {alu_e, alu_d} = {1'b0, alu_a} + {1'b0, alu_b} + {4'h0, alu_c};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_start(input logic [15:0] a, input logic [15:0] b, input logic [1:0] ct, input logic c);
    @(negedge clk);
    op_a = a; op_b = b; op_ctrl = ct; cin = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if ({busy, done, cout, alu_c} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {busy, done, cout, alu_c}); end
    n_cmp++; if ({result, alu_a, alu_b, alu_ctrl} !== 26'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", {result, alu_a, alu_b, alu_ctrl}); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_add;
    pulse_start(16'h1234, 16'h1111, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL add_busy%0d: got %b want 10", i, {busy, done}); end
      n_cmp++; if (alu_ctrl !== 2'b01) begin n_err++; $display("FAIL add_ctrl%0d: got %b want 01", i, alu_ctrl); end
      if (i == 0) begin
        n_cmp++; if ({alu_a, alu_b, alu_c} !== {4'h4, 4'h1, 1'b0}) begin n_err++; $display("FAIL add_nib0: got %h want %h", {alu_a, alu_b, alu_c}, {4'h4, 4'h1, 1'b0}); end
      end
    end
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL add_done: got %b want 01", {busy, done}); end
    n_cmp++; if ({result, cout} !== {16'h2345, 1'b0}) begin n_err++; $display("FAIL add_result: got %h/%b want 2345/0", result, cout); end
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL add_idle: got %b want 00", {busy, done}); end
  endtask

  task automatic test_ripple;
    pulse_start(16'h000F, 16'h0001, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_cmp++; if (alu_c !== 1'b1) begin n_err++; $display("FAIL ripple_cy: got %b want 1", alu_c); end
      end
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL ripple_done: got %b want 1", done); end
    n_cmp++; if ({result, cout} !== {16'h0010, 1'b0}) begin n_err++; $display("FAIL ripple_result: got %h/%b want 0010/0", result, cout); end
  endtask

  task automatic test_wrap;
    pulse_start(16'hFFFF, 16'h0000, 2'b11, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (alu_c !== 1'b1) begin n_err++; $display("FAIL wrap_c%0d: got %b want 1", i, alu_c); end
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL wrap_done: got %b want 1", done); end
    n_cmp++; if ({result, cout} !== {16'h0000, 1'b1}) begin n_err++; $display("FAIL wrap_result: got %h/%b want 0000/1", result, cout); end
`ifdef ALU16_ZERO_FLAG_EN
    n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL wrap_zero: got %b want 1", zero); end
`endif
  endtask

  task automatic test_ignore;
    pulse_start(16'h1234, 16'h1111, 2'b01, 1'b0);
    @(negedge clk);
    @(negedge clk);
    op_a = 16'hFFFF; op_b = 16'hFFFF; op_ctrl = 2'b10; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, done, alu_ctrl} !== 4'b1001) begin n_err++; $display("FAIL ignore_run: got %b want 1001", {busy, done, alu_ctrl}); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL ignore_done: got %b want 01", {busy, done}); end
    n_cmp++; if ({result, cout} !== {16'h2345, 1'b0}) begin n_err++; $display("FAIL ignore_result: got %h/%b want 2345/0", result, cout); end
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL ignore_noqueue: got %b want 00", {busy, done}); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    op_a = 16'h0101; op_b = 16'h0202; op_ctrl = 2'b10; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      n_cmp++; if (done !== (i == 4 || i == 9 || i == 14)) begin n_err++; $display("FAIL b2b_done%0d: got %b want %b", i, done, (i == 4 || i == 9 || i == 14)); end
      n_cmp++; if (busy === done) begin n_err++; $display("FAIL b2b_excl%0d: got busy=%b done=%b want opposite", i, busy, done); end
      if (busy) begin
        n_cmp++; if (alu_ctrl !== 2'b10) begin n_err++; $display("FAIL b2b_ctrl%0d: got %b want 10", i, alu_ctrl); end
      end
      if (done) begin
        n_cmp++; if (result !== 16'h0303) begin n_err++; $display("FAIL b2b_result%0d: got %h want 0303", i, result); end
      end
    end
    start = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL b2b_stop: got %b want 00", {busy, done}); end
  endtask

  task automatic test_reset_mid_run;
    pulse_start(16'hFFFF, 16'h0000, 2'b01, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_pre: got %b want 1", busy); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if ({busy, done, cout} !== 3'b000) begin n_err++; $display("FAIL midrst_flags: got %b want 000", {busy, done, cout}); end
    n_cmp++; if ({result, alu_a, alu_c, alu_ctrl} !== 23'h0) begin n_err++; $display("FAIL midrst_data: got %h want 0", {result, alu_a, alu_c, alu_ctrl}); end
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL midrst_after%0d: got %b want 00", i, {busy, done}); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_a = 16'h0; op_b = 16'h0; op_ctrl = 2'b00; cin = 1'b0;
    test_reset;
    test_add;
    test_ripple;
    test_wrap;
    test_ignore;
    test_back_to_back;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu16_nibble_seq.md
# alu16_nibble_seq

Multi-cycle sequencer that performs a 16-bit operation by streaming four nibbles through the team's existing 4-bit ripple ALU slice (4-bit a/b, 2-bit control, carry-in c, 4-bit result d, carry-out e). It sits directly upstream and downstream of that slice. It latches 16-bit operands, drives one nibble per clock LSB-first, chains the slice's carry-out into the next nibble's carry-in, and collects the four result nibbles into a 16-bit result. The sequencer is operation-agnostic: the control code is passed through unchanged and only carry chaining is interpreted.

## Interface
- Parameters: none (width fixed at 16 = 4 nibbles).
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled on rising edge when accepted (see Operation)
- op_a  in  16  operand A, latched on accepted start
- op_b  in  16  operand B, latched on accepted start
- op_ctrl  in  2  ALU control code, latched on accepted start
- cin  in  1  carry-in for nibble 0, latched on accepted start
- alu_a  out  4  nibble of A to slice
- alu_b  out  4  nibble of B to slice
- alu_c  out  1  carry-in to slice
- alu_ctrl  out  2  control code to slice
- alu_d  in  4  slice result (combinational from alu_* outputs)
- alu_e  in  1  slice carry-out
- result  out  16  assembled result, held until next accepted start
- cout  out  1  carry-out of nibble 3, held with result
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when result/cout become valid

## Operation
- States: IDLE, RUN, DONE. 2-bit nibble counter cnt, carry register cy.
- start accepted in IDLE or DONE: latch op_a/op_b/op_ctrl/cin, cnt<=0, go to RUN. start in RUN ignored (no queueing).
- RUN, cnt=k: alu_a=a_reg[4k+3:4k], alu_b=b_reg[4k+3:4k], alu_c=(k==0)?cin_reg:cy, alu_ctrl=ctrl_reg.
- Each RUN edge: result[4k+3:4k]<=alu_d, cy<=alu_e, cnt<=k+1. At k=3 also cout<=alu_e, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unless start accepted (DONE→RUN directly, done still 1 that cycle).
- IDLE/DONE: alu_a=alu_b=0, alu_c=0, alu_ctrl=ctrl_reg.
- Other result nibbles unchanged during RUN until written; result is only guaranteed valid when done=1 and after.

## Timing
- Reset (async, immediate): state IDLE, cnt=0, cy=0, all latches 0; result=0, cout=0, busy=0, done=0, alu_*=0.
- Reset mid-RUN aborts the operation; no done pulse; result reads 0.
- Start sampled at edge T0 → busy=1 for cycles T0–T4, nibble k presented in cycle after T(k), captured at T(k+1); done=1 cycle T4–T5. Latency start-edge→done = 4 clocks.
- Back-to-back: start held high continuously yields a done pulse every 5 clocks.
- Slice path alu_* → alu_d/alu_e is combinational within one cycle; no extra pipeline stage.
- busy and done are never high together.

## Configuration
- ALU16_ZERO_FLAG_EN defined: adds output zero (1 bit), registered at the DONE transition as (assembled result==16'h0000), reset 0, held with result.
- Not defined: zero port and its logic absent; all other behaviour identical.

## Test plan
Bench stub slice: d=(a+b+c)[3:0], e=carry; ctrl ignored.
- Reset asserted mid-RUN (cycle T2) → busy, done, result, cout read 0 immediately; no done pulse afterwards.
- op_a=16'h1234, op_b=16'h1111, cin=0, start one cycle → done exactly 4 clocks after start edge, result=16'h2345, cout=0.
- op_a=16'h000F, op_b=16'h0001, cin=0 → carry ripples nibble-to-nibble via cy: result=16'h0010, cout=0; alu_c=1 during nibble 1.
- op_a=16'hFFFF, op_b=16'h0000, cin=1 → result=16'h0000, cout=1; with ALU16_ZERO_FLAG_EN zero=1.
- start pulsed again during RUN with different operands → ignored; result matches first operands; start held high → done every 5 clocks, alu_ctrl equals latched op_ctrl throughout each RUN.
